// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-controlled 50%-duty clock divider with a handshaked
// half-period update that only takes effect at a full-period boundary.
// Optional feature: define CLK_DIV_CTRL_TICK_EN to add rise_tick/fall_tick.
module clk_div_ctrl #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
`ifdef CLK_DIV_CTRL_TICK_EN
  ,
  output logic             rise_tick,
  output logic             fall_tick
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_half;
  logic             pend;

  logic             cfg_fire;
  logic [CNT_W-1:0] cfg_clamped;
  logic             wrap;

  // A zero half-period would never toggle, so it is treated as one.
  assign cfg_fire    = cfg_valid & cfg_ready;
  assign cfg_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  // cur_half is never zero, so the subtraction cannot underflow.
  assign wrap        = (cnt == (cur_half - CNT_W'(1)));

  // Controller FSM: counter, divided clock, config handshake and ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      clk_out   <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      cur_half  <= CNT_W'(DEFAULT_HALF);
      pend_half <= '0;
      pend      <= 1'b0;
`ifdef CLK_DIV_CTRL_TICK_EN
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
`endif
    end else begin
`ifdef CLK_DIV_CTRL_TICK_EN
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
`endif
      // Capture. pend and cfg_ready are complementary, so a capture never
      // coincides with an apply below (apply tests the old pend value).
      if (cfg_fire) begin
        if (state == IDLE) begin
          cur_half <= cfg_clamped;
        end else begin
          pend_half <= cfg_clamped;
          pend      <= 1'b1;
          cfg_ready <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          // Leftover from a capture on the edge that truncated the run.
          if (pend) begin
            cur_half  <= pend_half;
            pend      <= 1'b0;
            cfg_ready <= 1'b1;
          end
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (!en && !clk_out) begin
            // Low phase: stopping now cannot produce a runt pulse.
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (pend) begin
              cur_half  <= pend_half;
              pend      <= 1'b0;
              cfg_ready <= 1'b1;
            end
          end else begin
            if (wrap) begin
              cnt     <= '0;
              clk_out <= ~clk_out;
`ifdef CLK_DIV_CTRL_TICK_EN
              rise_tick <= ~clk_out;
              fall_tick <= clk_out;
`endif
              if (clk_out && pend) begin
                cur_half  <= pend_half;
                pend      <= 1'b0;
                cfg_ready <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            // clk_out is high here, so a wrap is the falling toggle itself.
            if (!en) begin
              if (wrap) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= STOP_WAIT;
              end
            end
          end
        end

        STOP_WAIT: begin
          // clk_out is always high here; the wrap is the falling toggle.
          if (wrap) begin
            cnt     <= '0;
            clk_out <= 1'b0;
`ifdef CLK_DIV_CTRL_TICK_EN
            fall_tick <= 1'b1;
`endif
            if (pend) begin
              cur_half  <= pend_half;
              pend      <= 1'b0;
              cfg_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (en) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          cnt     <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl; tick checks only when
// CLK_DIV_CTRL_TICK_EN is defined.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_half;
  logic       cfg_ready;
  logic       clk_out;
  logic       busy;
  logic [7:0] cur_half;
`ifdef CLK_DIV_CTRL_TICK_EN
  logic       rise_tick;
  logic       fall_tick;
`endif

  int checks   = 0;
  int failures = 0;

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_HALF(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .busy      (busy),
    .cur_half  (cur_half)
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
`endif
  );

  always #5 clk = ~clk;

  // Advance one edge and settle before sampling / driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out got=%b exp=0", clk_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (cur_half !== 8'd4) begin failures++; $display("FAIL reset_cur_half got=%0d exp=4", cur_half); end
`ifdef CLK_DIV_CTRL_TICK_EN
    checks++; if (rise_tick !== 1'b0 || fall_tick !== 1'b0) begin failures++; $display("FAIL reset_ticks got=%b%b exp=00", rise_tick, fall_tick); end
`endif
  endtask

  // H=4: rise at k+4, fall at k+8, period 8.
  task automatic test_default_run();
    logic e;
    en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%b exp=1", busy); end
    for (int j = 1; j <= 16; j++) begin
      tick();
      e = ((j / 4) % 2) == 1;
      checks++; if (clk_out !== e) begin failures++; $display("FAIL run_h4 j=%0d clk_out got=%b exp=%b", j, clk_out, e); end
`ifdef CLK_DIV_CTRL_TICK_EN
      e = (j == 4) || (j == 12);
      checks++; if (rise_tick !== e) begin failures++; $display("FAIL rise_tick j=%0d got=%b exp=%b", j, rise_tick, e); end
      e = (j == 8) || (j == 16);
      checks++; if (fall_tick !== e) begin failures++; $display("FAIL fall_tick j=%0d got=%b exp=%b", j, fall_tick, e); end
`endif
    end
    // Just fell: stopping in the low phase is immediate.
    en = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin failures++; $display("FAIL stop_low busy=%b clk_out=%b exp=0 0", busy, clk_out); end
  endtask

  task automatic test_idle_cfg();
    logic e;
    cfg_valid = 1'b1; cfg_half = 8'd3;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cur_half !== 8'd3) begin failures++; $display("FAIL idle_cfg cur_half got=%0d exp=3", cur_half); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_cfg cfg_ready got=%b exp=1", cfg_ready); end
    en = 1'b1;
    tick();
    for (int j = 1; j <= 12; j++) begin
      tick();
      e = ((j / 3) % 2) == 1;
      checks++; if (clk_out !== e) begin failures++; $display("FAIL run_h3 j=%0d clk_out got=%b exp=%b", j, clk_out, e); end
    end
    en = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_h3 busy got=%b exp=0", busy); end
  endtask

  task automatic test_update_running();
    logic e;
    cfg_valid = 1'b1; cfg_half = 8'd4;
    tick();
    cfg_valid = 1'b0;
    en = 1'b1;
    tick();
    for (int j = 1; j <= 5; j++) tick();
    // Mid-high phase (cnt=1): offer H=2.
    cfg_valid = 1'b1; cfg_half = 8'd2;
    tick();                               // edge 6
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL upd_pending cfg_ready got=%b exp=0", cfg_ready); end
    checks++; if (cur_half !== 8'd4) begin failures++; $display("FAIL upd_pending cur_half got=%0d exp=4", cur_half); end
    cfg_half = 8'd7;                      // second offer while pending
    tick();                               // edge 7
    cfg_valid = 1'b0;
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL upd_edge7 clk_out got=%b exp=1", clk_out); end
    tick();                               // edge 8: falling toggle applies
    checks++; if (cur_half !== 8'd2) begin failures++; $display("FAIL upd_apply cur_half got=%0d exp=2", cur_half); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL upd_apply cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL upd_apply clk_out got=%b exp=0", clk_out); end
    for (int m = 1; m <= 8; m++) begin
      tick();
      e = ((m / 2) % 2) == 1;
      checks++; if (clk_out !== e) begin failures++; $display("FAIL run_h2 m=%0d clk_out got=%b exp=%b", m, clk_out, e); end
    end
    checks++; if (cur_half !== 8'd2) begin failures++; $display("FAIL second_offer cur_half got=%0d exp=2", cur_half); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_stop_high();
    cfg_valid = 1'b1; cfg_half = 8'd4;
    tick();
    cfg_valid = 1'b0;
    en = 1'b1;
    tick();
    for (int j = 1; j <= 4; j++) tick(); // rose at edge 4
    en = 1'b0;
    for (int j = 5; j <= 7; j++) begin
      tick();
      checks++; if (clk_out !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL stop_high j=%0d clk_out=%b busy=%b exp=1 1", j, clk_out, busy); end
    end
    tick();                               // edge 8: fall and IDLE
    checks++; if (clk_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_done clk_out=%b busy=%b exp=0 0", clk_out, busy); end
    tick();
    checks++; if (clk_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_idle clk_out=%b busy=%b exp=0 0", clk_out, busy); end
  endtask

  task automatic test_resume();
    en = 1'b1;
    tick();
    for (int j = 1; j <= 5; j++) tick();
    en = 1'b0;
    tick();                               // edge 6: STOP_WAIT
    en = 1'b1;
    tick(); tick();                       // edge 8: normal fall
    checks++; if (clk_out !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL resume_fall clk_out=%b busy=%b exp=0 1", clk_out, busy); end
    for (int j = 9; j <= 12; j++) tick();
    checks++; if (clk_out !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL resume_rise clk_out=%b busy=%b exp=1 1", clk_out, busy); end
    en = 1'b0;
    for (int j = 13; j <= 16; j++) tick();
    checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin failures++; $display("FAIL resume_stop busy=%b clk_out=%b exp=0 0", busy, clk_out); end
  endtask

  // H=0 clamps to 1; then a capture on a falling edge waits a period.
  // Ends running with H=3, just after a rise.
  task automatic test_clamp_and_fall_capture();
    logic e;
    cfg_valid = 1'b1; cfg_half = 8'd0;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cur_half !== 8'd1) begin failures++; $display("FAIL clamp cur_half got=%0d exp=1", cur_half); end
    en = 1'b1;
    tick();
    for (int j = 1; j <= 3; j++) begin
      tick();
      e = (j % 2) == 1;
      checks++; if (clk_out !== e) begin failures++; $display("FAIL run_h1 j=%0d clk_out got=%b exp=%b", j, clk_out, e); end
    end
    cfg_valid = 1'b1; cfg_half = 8'd3;
    tick();                               // edge 4: falling toggle + capture
    cfg_valid = 1'b0;
    checks++; if (cur_half !== 8'd1 || cfg_ready !== 1'b0) begin failures++; $display("FAIL fall_capture cur_half=%0d cfg_ready=%b exp=1 0", cur_half, cfg_ready); end
    tick();                               // edge 5
    checks++; if (cur_half !== 8'd1 || clk_out !== 1'b1) begin failures++; $display("FAIL fall_capture_e5 cur_half=%0d clk_out=%b exp=1 1", cur_half, clk_out); end
    tick();                               // edge 6: applied
    checks++; if (cur_half !== 8'd3 || cfg_ready !== 1'b1 || clk_out !== 1'b0) begin failures++; $display("FAIL fall_apply cur_half=%0d cfg_ready=%b clk_out=%b exp=3 1 0", cur_half, cfg_ready, clk_out); end
    tick(); tick();                       // edge 8
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL h3_e8 clk_out got=%b exp=0", clk_out); end
    tick();                               // edge 9
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL h3_e9 clk_out got=%b exp=1", clk_out); end
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1'b1; cfg_half = 8'd5;
    tick();                               // pending captured
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rmid_pending cfg_ready got=%b exp=0", cfg_ready); end
    reset = 1'b1;
    tick();
    checks++; if (clk_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || cur_half !== 8'd4) begin
      failures++; $display("FAIL rmid_state clk_out=%b busy=%b cfg_ready=%b cur_half=%0d exp=0 0 1 4", clk_out, busy, cfg_ready, cur_half);
    end
    reset = 1'b0;
    tick();                               // en still high: RUN entry
    for (int j = 1; j <= 3; j++) tick();
    checks++; if (clk_out !== 1'b0) begin failures++; $display("FAIL rmid_e3 clk_out got=%b exp=0", clk_out); end
    tick();
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL rmid_e4 clk_out got=%b exp=1", clk_out); end
    for (int j = 5; j <= 7; j++) tick();
    checks++; if (clk_out !== 1'b1) begin failures++; $display("FAIL rmid_e7 clk_out got=%b exp=1", clk_out); end
    tick();
    checks++; if (clk_out !== 1'b0 || cur_half !== 8'd4 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_e8 clk_out=%b cur_half=%0d cfg_ready=%b exp=0 4 1", clk_out, cur_half, cfg_ready);
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_idle_cfg();
    test_update_running();
    test_stop_high();
    test_resume();
    test_clamp_and_fall_capture();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
